// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: 8 requesters share one resource, with one-hot grant plus binary select index.
// Latency: request sampled in IDLE is granted at the same edge; one idle gap cycle between grants.
// Backpressure: owner holds until done, request drop or MAX_HOLD cycles; other requests wait.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state, state_n;
  logic [2:0] ptr, ptr_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] owner, owner_n;
  logic [7:0] gnt_n;
  logic [2:0] gnt_idx_n;
  logic       gnt_valid_n;
  logic       timeout_n;

  logic [2:0] sel;
  logic       found;
  logic       rel_norm;
  logic       rel_lim;

  // Rotating-priority search: first set request at or after ptr, wrapping 7 -> 0.
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && req[ptr + 3'(i)]) begin
        sel   = ptr + 3'(i);
        found = 1'b1;
      end
    end
  end

  assign rel_norm = done | ~req[owner];
  assign rel_lim  = (MAX_HOLD != 0) && (cnt == HOLD_LIM);

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    cnt_n       = cnt;
    owner_n     = owner;
    gnt_n       = gnt;
    gnt_idx_n   = gnt_idx;
    gnt_valid_n = gnt_valid;
    timeout_n   = 1'b0;
    case (state)
      IDLE: begin
        gnt_n       = 8'h00;
        gnt_valid_n = 1'b0;
        if (found) begin
          state_n     = GRANT;
          owner_n     = sel;
          gnt_n       = 8'h01 << sel;
          gnt_idx_n   = sel;
          gnt_valid_n = 1'b1;
          cnt_n       = 8'd1;
        end
      end
      GRANT: begin
        if (rel_norm || rel_lim) begin
          state_n     = IDLE;
          gnt_n       = 8'h00;
          gnt_valid_n = 1'b0;
          ptr_n       = owner + 3'd1;
          cnt_n       = 8'd0;
          // A coincident done/drop makes the release a normal one.
          timeout_n   = rel_lim & ~rel_norm;
        end else begin
          cnt_n = (cnt != 8'hFF) ? cnt + 8'd1 : cnt;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      cnt       <= 8'd0;
      owner     <= 3'd0;
      gnt       <= 8'h00;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      owner     <= owner_n;
      gnt       <= gnt_n;
      gnt_idx   <= gnt_idx_n;
      gnt_valid <= gnt_valid_n;
      timeout   <= timeout_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: two instances (hold limit 4 and unlimited) share stimulus;
// a per-cycle scoreboard plus a directed grant-order queue check both against a reference model.
module tb_rr_arbiter8;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] i;
    logic       v;
    logic       t;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;

  logic [7:0] gnt_a, gnt_b;
  logic [2:0] idx_a, idx_b;
  logic       vld_a, vld_b;
  logic       to_a, to_b;

  int checks = 0;
  int errors = 0;
  int cycle_no = 0;

  obs_t expa[$];
  obs_t expb[$];
  int   gord[$];
  bit   gord_en = 1'b0;

  // Reference model state, index 0 = limit 4, index 1 = unlimited.
  int mh[2] = '{4, 0};
  bit mbusy[2];
  int mown[2];
  int mheld[2];
  int mptr[2];
  int midx[2];
  bit mto[2];

  rr_arbiter8 #(.MAX_HOLD(4)) u_dut_a (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(vld_a), .timeout(to_a)
  );

  rr_arbiter8 #(.MAX_HOLD(0)) u_dut_b (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(vld_b), .timeout(to_b)
  );

  always #5 clk = ~clk;

  task automatic step(input int m, input bit r, input logic [7:0] rq, input bit d);
    bit norm, lim;
    if (r) begin
      mbusy[m] = 0; mown[m] = 0; mheld[m] = 0; mptr[m] = 0; midx[m] = 0; mto[m] = 0;
    end else if (!mbusy[m]) begin
      mto[m] = 0;
      for (int k = 0; k < 8; k++) begin
        if (!mbusy[m] && rq[(mptr[m] + k) % 8]) begin
          mbusy[m] = 1;
          mown[m]  = (mptr[m] + k) % 8;
          midx[m]  = mown[m];
          mheld[m] = 1;
        end
      end
    end else begin
      norm = d || !rq[mown[m]];
      lim  = (mh[m] != 0) && (mheld[m] == mh[m]);
      if (norm || lim) begin
        mbusy[m] = 0;
        mptr[m]  = (mown[m] + 1) % 8;
        mto[m]   = lim && !norm;
        mheld[m] = 0;
      end else begin
        mheld[m] = mheld[m] + 1;
        mto[m]   = 0;
      end
    end
  endtask

  function automatic obs_t expected(input int m);
    obs_t o;
    o.g = mbusy[m] ? (8'h01 << mown[m]) : 8'h00;
    o.i = 3'(midx[m]);
    o.v = mbusy[m];
    o.t = mto[m];
    return o;
  endfunction

  task automatic cyc(input bit r, input logic [7:0] rq, input bit d);
    rst  = r;
    req  = rq;
    done = d;
    for (int m = 0; m < 2; m++) step(m, r, rq, d);
    expa.push_back(expected(0));
    expb.push_back(expected(1));
    @(negedge clk);
  endtask

  task automatic idle2();
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
  endtask

  // Monitor: compares each DUT against the oldest expectation after every edge.
  initial begin
    obs_t e;
    int   gi;
    bit   prev_vld;
    prev_vld = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cycle_no++;
      if (expa.size() > 0) begin
        e = expa.pop_front();
        checks++;
        if ({gnt_a, idx_a, vld_a, to_a} !== e) begin
          errors++;
          $display("FAIL lim4 cyc %0d: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                   cycle_no, gnt_a, idx_a, vld_a, to_a, e.g, e.i, e.v, e.t);
        end
      end
      if (expb.size() > 0) begin
        e = expb.pop_front();
        checks++;
        if ({gnt_b, idx_b, vld_b, to_b} !== e) begin
          errors++;
          $display("FAIL nolim cyc %0d: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
                   cycle_no, gnt_b, idx_b, vld_b, to_b, e.g, e.i, e.v, e.t);
        end
      end
      if (gord_en && vld_a === 1'b1 && !prev_vld && gord.size() > 0) begin
        gi = gord.pop_front();
        checks++;
        if (int'(idx_a) != gi) begin
          errors++;
          $display("FAIL grant_order cyc %0d: got idx=%0d, want %0d", cycle_no, idx_a, gi);
        end
      end
      prev_vld = (vld_a === 1'b1);
    end
  end

  initial begin
    logic [7:0] rq;
    int budget;

    // Reset
    repeat (3) cyc(1, 8'h00, 0);

    // Reset priority, then full rotation
    gord_en = 1'b1;
    foreach (gord[k]) gord.delete(k);
    gord.push_back(0); gord.push_back(7); gord.push_back(0); gord.push_back(7);
    for (int k = 0; k < 8; k++) cyc(0, 8'h81, mbusy[0]);
    idle2();
    for (int k = 0; k < 8; k++) gord.push_back(k);
    gord.push_back(0);
    for (int k = 0; k < 18; k++) cyc(0, 8'hFF, mbusy[0]);
    idle2();
    gord_en = 1'b0;

    // Hold limit
    for (int k = 0; k < 12; k++) cyc(0, 8'h04, 0);
    idle2();

    // Simultaneous done and limit, then long unlimited hold
    cyc(0, 8'h04, 0);
    repeat (3) cyc(0, 8'h04, 0);
    cyc(0, 8'h04, 1);
    repeat (300) cyc(0, 8'h04, 0);
    idle2();

    // Request drop with late requesters, then reset mid-grant
    gord_en = 1'b1;
    gord.push_back(3); gord.push_back(5); gord.push_back(1);
    cyc(0, 8'h08, 0);
    cyc(0, 8'h08, 0);
    cyc(0, 8'h22, 0);
    cyc(0, 8'h22, 0);
    cyc(0, 8'h22, 1);
    cyc(0, 8'h22, 0);
    cyc(0, 8'h22, 1);
    idle2();
    gord.push_back(6); gord.push_back(6);
    cyc(0, 8'h40, 0);
    repeat (2) cyc(0, 8'h40, 0);
    cyc(1, 8'h40, 0);
    repeat (3) cyc(0, 8'h40, 0);
    idle2();
    gord_en = 1'b0;

    // Random traffic
    rq = 8'h00;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 2) == 0) rq = 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 199) == 0), rq, ($urandom_range(0, 3) == 0));
    end
    idle2();

    budget = 20;
    while ((expa.size() > 0 || expb.size() > 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (expa.size() > 0 || expb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", expa.size(), expb.size());
    end
    checks++;
    if (gord.size() != 0) begin
      errors++;
      $display("FAIL grant_order_left: got %0d unobserved grants, want 0", gord.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
